sb_tx_scheduler: RTL and testbench

Sideband transmit scheduler for the USB4 logical layer. It shares the single sideband byte serializer (driving `sbtx`) between three packet sources: Link Transactions (LT), AT responses (ATR) and AT commands (ATC). It also tracks the one outstanding AT command, running a response timer with bounded replay. It sits between the LT/AT packet builders and the sideband serializer, clocked by the sideband clock.

---
 rtl/sb_tx_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_sb_tx_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_scheduler.sv
// -----------------------------------------------------------------------------
// sb_tx_scheduler
//
// Shares the single sideband byte serializer between three packet sources:
// Link Transactions (LT), AT responses (ATR) and AT commands (ATC). A source
// keeps its request up until its last byte is acked. Once a packet is granted
// it runs to completion, and a fixed idle gap follows it. A second FSM tracks
// the one outstanding AT command. It runs a response timer, asks the ATC
// source to replay on timeout, and flags an error once the replays run out.
//
// Ports
//   sb_clk, rst            sideband clock; synchronous active-low reset
//   {lt,atr,atc}_req       source has a packet ready
//   {lt,atr,atc}_byte      current byte of that source
//   {lt,atr,atc}_last      current byte is the final byte of the packet
//   {lt,atr,atc}_ack       byte consumed this cycle
//   ser_byte/ser_valid     byte to the serializer
//   ser_ready              serializer accepts a byte this cycle
//   at_rsp_rcvd            pulse: response to the outstanding AT command seen
//   atc_replay             pulse: ATC source must re-present its command
//   at_timeout_err         pulse: all replays exhausted without a response
//   grant_id               0 none, 1 LT, 2 ATR, 3 ATC
//   busy                   arbiter not idle
// -----------------------------------------------------------------------------
module sb_tx_scheduler #(
  parameter int AT_TIMEOUT = 1000,
  parameter int MAX_RETRY  = 2,
  parameter int GAP_CYC    = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       lt_req,
  input  logic [7:0] lt_byte,
  input  logic       lt_last,
  output logic       lt_ack,
  input  logic       atr_req,
  input  logic [7:0] atr_byte,
  input  logic       atr_last,
  output logic       atr_ack,
  input  logic       atc_req,
  input  logic [7:0] atc_byte,
  input  logic       atc_last,
  output logic       atc_ack,
  output logic [7:0] ser_byte,
  output logic       ser_valid,
  input  logic       ser_ready,
  input  logic       at_rsp_rcvd,
  output logic       atc_replay,
  output logic       at_timeout_err,
  output logic [1:0] grant_id,
  output logic       busy
);

  // Widths are clamped to one bit so that degenerate parameter values
  // still elaborate.
  localparam int TW = (AT_TIMEOUT > 1) ? $clog2(AT_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [TW-1:0] TMR_LAST = TW'(AT_TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LT   = 2'd1;
  localparam logic [1:0] G_ATR  = 2'd2;
  localparam logic [1:0] G_ATC  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} arb_st_e;
  typedef enum logic {AT_IDLE, AT_WAIT} at_st_e;

  arb_st_e       arb_q, arb_d;
  logic [1:0]    grant_q, grant_d;
  logic [GW-1:0] gap_q, gap_d;

  at_st_e        at_q, at_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [RW-1:0] rty_q, rty_d;

  logic          sel_last;
  logic          atc_done;   // last byte of an ATC packet handed over

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_d     = arb_q;
    grant_d   = grant_q;
    gap_d     = gap_q;
    ser_valid = 1'b0;
    ser_byte  = 8'h00;
    sel_last  = 1'b0;
    lt_ack    = 1'b0;
    atr_ack   = 1'b0;
    atc_ack   = 1'b0;
    atc_done  = 1'b0;

    case (arb_q)
      ST_IDLE: begin
        // Fixed priority LT > ATR > ATC. ATC waits while a command is
        // still outstanding.
        if (lt_req) begin
          grant_d = G_LT;
          arb_d   = ST_XFER;
        end else if (atr_req) begin
          grant_d = G_ATR;
          arb_d   = ST_XFER;
        end else if (atc_req && (at_q == AT_IDLE)) begin
          grant_d = G_ATC;
          arb_d   = ST_XFER;
        end
      end

      ST_XFER: begin
        ser_valid = 1'b1;
        case (grant_q)
          G_LT: begin
            ser_byte = lt_byte;
            sel_last = lt_last;
            lt_ack   = ser_ready;
          end
          G_ATR: begin
            ser_byte = atr_byte;
            sel_last = atr_last;
            atr_ack  = ser_ready;
          end
          G_ATC: begin
            ser_byte = atc_byte;
            sel_last = atc_last;
            atc_ack  = ser_ready;
          end
          default: begin
            // No owner: this state is unreachable, so drop back to idle.
            ser_valid = 1'b0;
            arb_d     = ST_IDLE;
          end
        endcase

        if (ser_valid && ser_ready && sel_last) begin
          atc_done = (grant_q == G_ATC);
          grant_d  = G_NONE;
          gap_d    = '0;
          arb_d    = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) arb_d = ST_IDLE;
        else                   gap_d = gap_q + 1'b1;
      end

      default: arb_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // AT command tracker
  // ---------------------------------------------------------------------------
  always_comb begin
    at_d           = at_q;
    tmr_d          = tmr_q;
    rty_d          = rty_q;
    atc_replay     = 1'b0;
    at_timeout_err = 1'b0;

    case (at_q)
      AT_IDLE: begin
        tmr_d = '0;
        if (atc_done) at_d = AT_WAIT;
      end

      AT_WAIT: begin
        // The response is checked first so that it wins a same-cycle
        // race with the timeout.
        if (at_rsp_rcvd) begin
          at_d  = AT_IDLE;
          rty_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          at_d = AT_IDLE;
          if (rty_q < RTY_MAX) begin
            atc_replay = 1'b1;
            rty_d      = rty_q + 1'b1;
          end else begin
            at_timeout_err = 1'b1;
            rty_d          = '0;
          end
        end else begin
          // The timer only counts up to TMR_LAST, so it saturates there.
          tmr_d = tmr_q + 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sb_clk) begin
    if (!rst) begin
      arb_q   <= ST_IDLE;
      grant_q <= G_NONE;
      gap_q   <= '0;
      at_q    <= AT_IDLE;
      tmr_q   <= '0;
      rty_q   <= '0;
    end else begin
      arb_q   <= arb_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      at_q    <= at_d;
      tmr_q   <= tmr_d;
      rty_q   <= rty_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (arb_q != ST_IDLE);

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sb_tx_scheduler
//
// Scoreboarded bench for sb_tx_scheduler. Directed stimulus pushes each
// expected serializer byte into one queue, tagged with its grant and the
// cycle in which it must be handshaken. Each expected replay or timeout
// pulse goes into a second queue, tagged with the cycle it is due. A
// monitor running on the falling edge pops and compares whenever the DUT
// hands over a byte or pulses. Every expected cycle is worked out by hand
// from these rules:
//   - a request seen in IDLE is valid on the next cycle;
//   - the next packet becomes valid last_hs + GAP + 2 cycles after the
//     previous last-byte handshake;
//   - a pulse comes AT_TIMEOUT cycles after the ATC last-byte handshake.
// -----------------------------------------------------------------------------
module tb_sb_tx_scheduler;

  localparam int AT_TO = 1000;
  localparam int MAXR  = 2;
  localparam int GAP   = 2;

  logic       sb_clk = 1'b0;
  logic       rst;
  logic       lt_req, atr_req, atc_req;
  logic [7:0] lt_byte, atr_byte, atc_byte;
  logic       lt_last, atr_last, atc_last;
  logic       lt_ack, atr_ack, atc_ack;
  logic [7:0] ser_byte;
  logic       ser_valid, ser_ready;
  logic       at_rsp_rcvd, atc_replay, at_timeout_err;
  logic [1:0] grant_id;
  logic       busy;

  sb_tx_scheduler #(.AT_TIMEOUT(AT_TO), .MAX_RETRY(MAXR), .GAP_CYC(GAP)) dut (
    .sb_clk(sb_clk), .rst(rst),
    .lt_req(lt_req), .lt_byte(lt_byte), .lt_last(lt_last), .lt_ack(lt_ack),
    .atr_req(atr_req), .atr_byte(atr_byte), .atr_last(atr_last), .atr_ack(atr_ack),
    .atc_req(atc_req), .atc_byte(atc_byte), .atc_last(atc_last), .atc_ack(atc_ack),
    .ser_byte(ser_byte), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .at_rsp_rcvd(at_rsp_rcvd), .atc_replay(atc_replay),
    .at_timeout_err(at_timeout_err), .grant_id(grant_id), .busy(busy)
  );

  always #5 sb_clk = ~sb_clk;

  int cyc = 0;
  always @(posedge sb_clk) cyc <= cyc + 1;

  typedef struct { int gid; int b; int c; } exp_t;
  typedef struct { int k; int c; } ev_t;   // k: 1 replay, 2 timeout error
  exp_t exp_q[$];
  ev_t  ev_q[$];
  exp_t e_m;
  ev_t  v_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, expv);
    end
  endtask

  // ---- source models: hold the request until the last byte is acked ----
  logic [7:0] pk [3][4];
  bit         pa [3];
  int         pi [3];
  bit         hs [3];

  task automatic drive();
    lt_req  = pa[0]; lt_byte  = pk[0][pi[0]]; lt_last  = (pi[0] == 3);
    atr_req = pa[1]; atr_byte = pk[1][pi[1]]; atr_last = (pi[1] == 3);
    atc_req = pa[2]; atc_byte = pk[2][pi[2]]; atc_last = (pi[2] == 3);
  endtask

  task automatic start_pkt(input int s, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    pk[s][0] = b0; pk[s][1] = b1; pk[s][2] = b2; pk[s][3] = b3;
    pi[s] = 0; pa[s] = 1'b1;
    drive();
  endtask

  task automatic start_seq(input int s, input int base);
    start_pkt(s, 8'(base), 8'(base + 1), 8'(base + 2), 8'(base + 3));
  endtask

  task automatic push(input int g, input int b, input int c);
    exp_t e;
    e.gid = g; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  // Four sequential bytes from source s, handshaken on back-to-back cycles.
  task automatic push4(input int s, input int base, input int c0);
    for (int i = 0; i < 4; i++) push(s + 1, base + i, c0 + i);
  endtask

  task automatic push_ev(input int k, input int c);
    ev_t v;
    v.k = k; v.c = c;
    ev_q.push_back(v);
  endtask

  task automatic kill_sources();
    for (int s = 0; s < 3; s++) pa[s] = 1'b0;
    drive();
  endtask

  // Acks are sampled mid-cycle; sources advance just after the edge.
  initial forever begin
    @(negedge sb_clk);
    hs[0] = lt_ack; hs[1] = atr_ack; hs[2] = atc_ack;
    @(posedge sb_clk);
    #1;
    for (int s = 0; s < 3; s++)
      if (pa[s] && hs[s]) begin
        if (pi[s] == 3) pa[s] = 1'b0;
        else            pi[s]++;
      end
    drive();
  end

  // ---- monitor ----
  initial forever begin
    @(negedge sb_clk);
    if (rst === 1'b1) begin
      if (ser_valid === 1'b1 && ser_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexp_byte", exp_q.size(), 1);
        else begin
          e_m = exp_q.pop_front();
          chk("byte",  ser_byte, e_m.b);
          chk("grant", grant_id, e_m.gid);
          chk("cycle", cyc, e_m.c);
          chk("ack",   {atc_ack, atr_ack, lt_ack}, 32'd1 << (e_m.gid - 1));
        end
      end else begin
        chk("no_ack", {atc_ack, atr_ack, lt_ack}, 0);
      end
      if (atc_replay !== 1'b0 || at_timeout_err !== 1'b0) begin
        if (ev_q.size() == 0) chk("unexp_pulse", {at_timeout_err, atc_replay}, 0);
        else begin
          v_m = ev_q.pop_front();
          chk("pulse_kind", {at_timeout_err, atc_replay}, v_m.k);
          chk("pulse_cyc",  cyc, v_m.c);
        end
      end
    end
  end

  // ---- stimulus ----
  // Run until cycle c; inputs set afterwards apply to cycle c.
  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge sb_clk);
      #2;
    end
  endtask

  task automatic neg_at(input int c);
    to_cyc(c);
    @(negedge sb_clk);
  endtask

  task automatic rsp_at(input int c);
    to_cyc(c);     at_rsp_rcvd = 1'b1;
    to_cyc(c + 1); at_rsp_rcvd = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"},  ser_valid, 0);
    chk({tag, "_byte"},   ser_byte, 0);
    chk({tag, "_acks"},   {atc_ack, atr_ack, lt_ack}, 0);
    chk({tag, "_replay"}, atc_replay, 0);
    chk({tag, "_err"},    at_timeout_err, 0);
    chk({tag, "_grant"},  grant_id, 0);
    chk({tag, "_busy"},   busy, 0);
  endtask

  initial begin
    rst = 1'b0; ser_ready = 1'b1; at_rsp_rcvd = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pa[s] = 1'b0; pi[s] = 0;
      for (int i = 0; i < 4; i++) pk[s][i] = 8'h00;
    end
    drive();

    neg_at(3);
    chk_reset_outs("rst");
    to_cyc(4); rst = 1'b1;

    // All three sources at once: LT, then ATR, then ATC, with a gap between.
    to_cyc(10);
    start_seq(0, 'h10); start_seq(1, 'h20); start_seq(2, 'h30);
    push4(0, 'h10, 11); push4(1, 'h20, 18); push4(2, 'h30, 25);
    neg_at(11); chk("lat_valid", ser_valid, 1); chk("lat_grant", grant_id, 1);
    neg_at(15); chk("gap_valid", ser_valid, 0); chk("gap_grant", grant_id, 0);
    chk("gap_busy", busy, 1);
    neg_at(17); chk("idle_busy", busy, 0);
    rsp_at(528);                         // 500 cycles after the ATC hs at 28

    // ATC with no response: replay, replay, error, then a replay again
    // because the retry count was cleared.
    to_cyc(540);  start_seq(2, 'h40); push4(2, 'h40, 541);  push_ev(1, 1544);
    // LT/ATR flow freely while ATC waits for the tracker.
    to_cyc(640);
    start_seq(0, 'h50); start_seq(1, 'h60); start_seq(2, 'h40);
    push4(0, 'h50, 641); push4(1, 'h60, 648);
    push4(2, 'h40, 1546); push_ev(1, 2549);
    neg_at(1545); chk("atc_held", ser_valid, 0);
    to_cyc(2000); start_seq(2, 'h40); push4(2, 'h40, 2551); push_ev(2, 3554);
    to_cyc(3000); start_seq(2, 'h40); push4(2, 'h40, 3556); push_ev(1, 4559);
    rsp_at(4600);                        // tracker idle: ignored

    // Response lands in the same cycle as the timeout: no pulse.
    to_cyc(4700); start_seq(2, 'h48); push4(2, 'h48, 4701);
    rsp_at(5704);

    // Serializer stall on byte 0xA5.
    to_cyc(5800);
    start_pkt(0, 8'h11, 8'hA5, 8'h22, 8'h33);
    push(1, 'h11, 5801); push(1, 'hA5, 5804); push(1, 'h22, 5805); push(1, 'h33, 5806);
    to_cyc(5802); ser_ready = 1'b0;
    @(negedge sb_clk); chk("stall_byte", ser_byte, 'hA5); chk("stall_valid", ser_valid, 1);
    neg_at(5803);      chk("stall_byte2", ser_byte, 'hA5);
    to_cyc(5804); ser_ready = 1'b1;

    // Reset while byte 2 of an ATC packet is on the bus.
    to_cyc(5900); start_seq(2, 'h70); push(3, 'h70, 5901); push(3, 'h71, 5902);
    to_cyc(5903); rst = 1'b0; ser_ready = 1'b0; kill_sources();
    to_cyc(5904); rst = 1'b1; ser_ready = 1'b1;
    @(negedge sb_clk);
    chk_reset_outs("rstmid");

    // Reset while the tracker waits: no replay afterwards, ATC eligible at once.
    to_cyc(5910); start_seq(2, 'h80); push4(2, 'h80, 5911);
    to_cyc(6000); start_seq(0, 'h90); push(1, 'h90, 6001); push(1, 'h91, 6002);
    to_cyc(6003); rst = 1'b0; ser_ready = 1'b0; kill_sources();
    to_cyc(6004); rst = 1'b1; ser_ready = 1'b1;
    to_cyc(6010); start_seq(2, 'hA0); push4(2, 'hA0, 6011);
    rsp_at(6100);

    to_cyc(7100);
    chk("bytes_left",  exp_q.size(), 0);
    chk("pulses_left", ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
